mwb_stage: RTL and testbench

- Memory/writeback stage of the 3-stage RV32I pipeline; sits directly downstream of the execute stage.
- Registers the execute-stage result and issues loads/stores to the data cache over a valid/ready request channel. Aligns and extends load data, then drives the register-file write port.
- Exports its in-flight instruction for execute-stage forwarding, raises stall while a memory access is outstanding, and holds the tohost CSR.

---
 rtl/mwb_stage_if.sv | 20 ++
 rtl/mwb_stage.sv | 176 +++++++++++++++++
 tb/tb_mwb_stage.sv | 357 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mwb_stage_if.sv
// Data-cache request/response channel between mwb_stage (master) and the data cache (slave).
interface mwb_stage_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] addr;
   logic [3:0]  we;
   logic [31:0] din;
   logic        resp_valid;
   logic [31:0] dout;

   modport master (
      output req_valid, addr, we, din,
      input  req_ready, resp_valid, dout
   );

   modport slave (
      input  req_valid, addr, we, din,
      output req_ready, resp_valid, dout
   );
endinterface

// File: rtl/mwb_stage.sv
// RV32I memory/writeback stage: dcache request FSM, load alignment, register-file write, tohost CSR.
// Optional macro MWB_PERF_CNT_EN adds instret_cnt / stall_cnt outputs.
module mwb_stage #(
   parameter logic [31:0] NOP_INST   = 32'h0000_0013,
   parameter logic [11:0] TOHOST_CSR = 12'h51E
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] x_inst,
   input  logic [31:0] x_alu_out,
   input  logic [31:0] x_pc_plus4,
   input  logic [31:0] x_store_data,
   input  logic [31:0] x_csr_data,
   mwb_stage_if.master dcache,
   output logic        stall,
   output logic [31:0] mwb_inst,
   output logic        wb_we,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data,
   output logic [31:0] csr_tohost
`ifdef MWB_PERF_CNT_EN
   ,
   output logic [31:0] instret_cnt,
   output logic [31:0] stall_cnt
`endif
);

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [1:0] {RUN, REQ, WAIT} state_t;

   state_t      state, state_nxt;
   logic [31:0] inst, alu_out, pc_plus4, store_data, csr_data;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        is_load, is_store, is_mem, is_jump, writes_rd, is_tohost;
   logic        req_valid, complete;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;
   logic [3:0]  st_we;
   logic [31:0] st_din;

   assign opcode    = inst[6:0];
   assign funct3    = inst[14:12];
   assign is_load   = (opcode == OPC_LOAD);
   assign is_store  = (opcode == OPC_STORE);
   assign is_mem    = is_load | is_store;
   assign is_jump   = (opcode == OPC_JAL) | (opcode == OPC_JALR);
   assign writes_rd = is_load | is_jump | (opcode == OPC_OP) | (opcode == OPC_OPIMM) |
                      (opcode == OPC_LUI) | (opcode == OPC_AUIPC);
   assign is_tohost = (opcode == OPC_SYSTEM) && ((funct3 == 3'b001) || (funct3 == 3'b101)) &&
                      (inst[31:20] == TOHOST_CSR);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= RUN;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RUN:  if (is_mem) state_nxt = dcache.req_ready ? (is_load ? WAIT : RUN) : REQ;
         REQ:  if (dcache.req_ready) state_nxt = is_load ? WAIT : RUN;
         WAIT: if (dcache.resp_valid) state_nxt = RUN;
         default: state_nxt = RUN;
      endcase
   end

   // A load never completes on acceptance; it completes on its response in WAIT.
   always_comb begin
      req_valid = 1'b0;
      complete  = 1'b0;
      case (state)
         RUN: begin
            req_valid = is_mem;
            complete  = !is_mem || (is_store && dcache.req_ready);
         end
         REQ: begin
            req_valid = 1'b1;
            complete  = is_store && dcache.req_ready;
         end
         WAIT:    complete = dcache.resp_valid;
         default: ;
      endcase
   end

   assign stall = is_mem && !complete;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inst       <= NOP_INST;
         alu_out    <= '0;
         pc_plus4   <= '0;
         store_data <= '0;
         csr_data   <= '0;
      end else if (!stall) begin
         inst       <= x_inst;
         alu_out    <= x_alu_out;
         pc_plus4   <= x_pc_plus4;
         store_data <= x_store_data;
         csr_data   <= x_csr_data;
      end
   end

   always_comb begin
      case (alu_out[1:0])
         2'd0:    ld_byte = dcache.dout[7:0];
         2'd1:    ld_byte = dcache.dout[15:8];
         2'd2:    ld_byte = dcache.dout[23:16];
         default: ld_byte = dcache.dout[31:24];
      endcase
      ld_half = alu_out[1] ? dcache.dout[31:16] : dcache.dout[15:0];
      case (funct3)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_data = {24'd0, ld_byte};
         3'b101:  ld_data = {16'd0, ld_half};
         default: ld_data = dcache.dout;
      endcase
   end

   always_comb begin
      st_we  = 4'b0000;
      st_din = store_data;
      if (is_store) begin
         case (funct3[1:0])
            2'b00: begin
               st_we  = 4'b0001 << alu_out[1:0];
               st_din = {4{store_data[7:0]}};
            end
            2'b01: begin
               st_we  = 4'b0011 << {alu_out[1], 1'b0};
               st_din = {2{store_data[15:0]}};
            end
            default: st_we = 4'b1111;
         endcase
      end
   end

   assign dcache.req_valid = req_valid;
   assign dcache.addr      = {alu_out[31:2], 2'b00};
   assign dcache.we        = st_we;
   assign dcache.din       = st_din;

   assign mwb_inst = inst;
   assign wb_rd    = inst[11:7];
   assign wb_we    = complete && writes_rd && (inst[11:7] != 5'd0);
   assign wb_data  = is_load ? ld_data : (is_jump ? pc_plus4 : alu_out);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                      csr_tohost <= '0;
      else if (is_tohost && complete) csr_tohost <= csr_data;
   end

`ifdef MWB_PERF_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instret_cnt <= '0;
         stall_cnt   <= '0;
      end else begin
         if (complete && (inst != NOP_INST)) instret_cnt <= instret_cnt + 32'd1;
         if (stall)                          stall_cnt   <= stall_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mwb_stage.sv
// Self-checking bench for mwb_stage: writeback scoreboard plus per-scenario inline checks.
module tb_mwb_stage;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] x_inst = NOP;
   logic [31:0] x_alu_out = '0, x_pc_plus4 = '0, x_store_data = '0, x_csr_data = '0;
   logic        stall, wb_we;
   logic [31:0] mwb_inst, wb_data, csr_tohost;
   logic [4:0]  wb_rd;
`ifdef MWB_PERF_CNT_EN
   logic [31:0] instret_cnt, stall_cnt;
`endif

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_exp_t;
   wb_exp_t sb[$];

   mwb_stage_if dc_if ();

   mwb_stage dut (
      .clk          (clk),
      .reset        (reset),
      .x_inst       (x_inst),
      .x_alu_out    (x_alu_out),
      .x_pc_plus4   (x_pc_plus4),
      .x_store_data (x_store_data),
      .x_csr_data   (x_csr_data),
      .dcache       (dc_if),
      .stall        (stall),
      .mwb_inst     (mwb_inst),
      .wb_we        (wb_we),
      .wb_rd        (wb_rd),
      .wb_data      (wb_data),
      .csr_tohost   (csr_tohost)
`ifdef MWB_PERF_CNT_EN
      ,
      .instret_cnt  (instret_cnt),
      .stall_cnt    (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Scoreboard consumer: every writeback the DUT makes must match the oldest expectation.
   always @(negedge clk) begin
      if (wb_we) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL wb_unexpected: got rd=%0d data=%h, expected no writeback", wb_rd, wb_data);
         end else begin
            wb_exp_t e;
            e = sb.pop_front();
            if (wb_rd !== e.rd || wb_data !== e.data) begin
               failures++;
               $display("FAIL wb_match: got rd=%0d data=%h, expected rd=%0d data=%h",
                        wb_rd, wb_data, e.rd, e.data);
            end
         end
      end
   end

   function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] rd,
                                      input logic [2:0] f3, input logic [11:0] imm);
      return {imm, 5'd1, f3, rd, opc};
   endfunction

   task automatic push_wb(input logic [4:0] rd, input logic [31:0] data);
      wb_exp_t e;
      e.rd = rd;
      e.data = data;
      sb.push_back(e);
   endtask

   // Entered and left at posedge+1; the instruction is in the stage on return.
   task automatic issue(input logic [31:0] inst, input logic [31:0] alu, input logic [31:0] pc4,
                        input logic [31:0] sd, input logic [31:0] csr);
      x_inst = inst; x_alu_out = alu; x_pc_plus4 = pc4; x_store_data = sd; x_csr_data = csr;
      @(posedge clk); #1;
      x_inst = NOP; x_alu_out = '0; x_pc_plus4 = '0; x_store_data = '0; x_csr_data = '0;
   endtask

   task automatic sb_drained(input string name);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL %s_drain: %0d writebacks outstanding, expected 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (dc_if.req_valid !== 1'b0 || dc_if.we !== 4'd0 || stall !== 1'b0 || wb_we !== 1'b0 ||
          wb_rd !== 5'd0 || wb_data !== 32'd0 || mwb_inst !== NOP || csr_tohost !== 32'd0) begin
         failures++;
         $display("FAIL reset_outputs: rv=%b we=%b stall=%b wbwe=%b rd=%0d wbd=%h inst=%h th=%h, expected all 0, inst=%h",
                  dc_if.req_valid, dc_if.we, stall, wb_we, wb_rd, wb_data, mwb_inst, csr_tohost, NOP);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      dc_if.req_ready = 1'b1;
      issue(mk(7'b0000011, 5'd7, 3'b010, 12'd0), 32'h40, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (stall !== 1'b1) begin
         failures++;
         $display("FAIL rst_lw_issue_stall: got %b expected 1", stall);
      end
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (stall !== 1'b1 || dc_if.req_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_wait_state: stall=%b rv=%b expected stall=1 rv=0", stall, dc_if.req_valid);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b0 || mwb_inst !== NOP || dc_if.req_valid !== 1'b0) begin
         failures++;
         $display("FAIL rst_async: stall=%b inst=%h rv=%b expected 0/%h/0", stall, mwb_inst, dc_if.req_valid, NOP);
      end
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || mwb_inst !== NOP) begin
         failures++;
         $display("FAIL rst_after: stall=%b inst=%h expected 0/%h", stall, mwb_inst, NOP);
      end
      @(posedge clk); #1;
      dc_if.resp_valid = 1'b1;
      dc_if.dout = 32'hDEAD_BEEF;
      @(negedge clk);
      checks++;
      if (wb_we !== 1'b0) begin
         failures++;
         $display("FAIL rst_late_resp: wb_we=%b expected 0", wb_we);
      end
      @(posedge clk); #1;
      dc_if.resp_valid = 1'b0;
      sb_drained("reset");
   endtask

   task automatic test_alu();
      push_wb(5'd5, 32'h1234);
      issue(mk(7'b0110011, 5'd5, 3'b000, 12'd0), 32'h1234, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (wb_we !== 1'b1 || stall !== 1'b0) begin
         failures++;
         $display("FAIL alu_add_x5: wb_we=%b stall=%b expected 1/0", wb_we, stall);
      end
      @(posedge clk); #1;
      issue(mk(7'b0110011, 5'd0, 3'b000, 12'd0), 32'h5678, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (wb_we !== 1'b0) begin
         failures++;
         $display("FAIL alu_add_x0: wb_we=%b expected 0", wb_we);
      end
      @(posedge clk); #1;
      sb_drained("alu");
   endtask

   task automatic test_store_stall();
      int nv = 0, ns = 0;
      dc_if.req_ready = 1'b0;
      issue(mk(7'b0100011, 5'd3, 3'b000, 12'd0), 32'h1003, 0, 32'hAB, 0);
      for (int i = 0; i < 3; i++) begin
         if (i == 2) dc_if.req_ready = 1'b1;
         @(negedge clk);
         if (dc_if.req_valid === 1'b1) nv++;
         if (stall === 1'b1) ns++;
         checks++;
         if (dc_if.we !== 4'b1000 || dc_if.din !== 32'hABABABAB || dc_if.addr !== 32'h1000) begin
            failures++;
            $display("FAIL sb_bus_c%0d: we=%b din=%h addr=%h expected 1000/ABABABAB/00001000",
                     i, dc_if.we, dc_if.din, dc_if.addr);
         end
         @(posedge clk); #1;
      end
      checks++;
      if (nv != 3 || ns != 2) begin
         failures++;
         $display("FAIL sb_counts: req_valid cycles=%0d stall cycles=%0d expected 3/2", nv, ns);
      end
      @(negedge clk);
      checks++;
      if (dc_if.req_valid !== 1'b0) begin
         failures++;
         $display("FAIL sb_done: req_valid=%b expected 0", dc_if.req_valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_store_enc();
      logic [2:0]  f3[2]   = '{3'b001, 3'b010};
      logic [31:0] ad[2]   = '{32'h2002, 32'h3001};
      logic [3:0]  ewe[2]  = '{4'b1100, 4'b1111};
      logic [31:0] edin[2] = '{32'h56785678, 32'h12345678};
      logic [31:0] eadr[2] = '{32'h2000, 32'h3000};
      dc_if.req_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         issue(mk(7'b0100011, 5'd0, f3[i], 12'd0), ad[i], 0, 32'h12345678, 0);
         @(negedge clk);
         checks++;
         if (dc_if.we !== ewe[i] || dc_if.din !== edin[i] || dc_if.addr !== eadr[i] ||
             stall !== 1'b0 || dc_if.req_valid !== 1'b1) begin
            failures++;
            $display("FAIL store_enc_%0d: we=%b din=%h addr=%h stall=%b rv=%b expected %b/%h/%h/0/1",
                     i, dc_if.we, dc_if.din, dc_if.addr, stall, dc_if.req_valid, ewe[i], edin[i], eadr[i]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic do_load(input string name, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] addr, input logic [31:0] dout, input logic [31:0] exp,
                          input int waits);
      dc_if.req_ready = 1'b1;
      issue(mk(7'b0000011, rd, f3, 12'd0), addr, 0, 0, 0);
      @(negedge clk);
      checks++;
      if (stall !== 1'b1 || dc_if.req_valid !== 1'b1 || dc_if.we !== 4'd0 ||
          dc_if.addr !== {addr[31:2], 2'b00}) begin
         failures++;
         $display("FAIL %s_req: stall=%b rv=%b we=%b addr=%h expected 1/1/0000/%h",
                  name, stall, dc_if.req_valid, dc_if.we, dc_if.addr, {addr[31:2], 2'b00});
      end
      @(posedge clk); #1;
      for (int i = 0; i < waits; i++) begin
         @(negedge clk);
         checks++;
         if (stall !== 1'b1 || dc_if.req_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_wait%0d: stall=%b rv=%b expected 1/0", name, i, stall, dc_if.req_valid);
         end
         @(posedge clk); #1;
      end
      dc_if.dout = dout;
      dc_if.resp_valid = 1'b1;
      push_wb(rd, exp);
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || wb_we !== 1'b1) begin
         failures++;
         $display("FAIL %s_resp: stall=%b wb_we=%b expected 0/1", name, stall, wb_we);
      end
      @(posedge clk); #1;
      dc_if.resp_valid = 1'b0;
   endtask

   task automatic test_load();
      do_load("lh",   3'b001, 5'd6, 32'h2002, 32'h8001_7FFF, 32'hFFFF_8001, 2);
      do_load("lhu",  3'b101, 5'd6, 32'h2002, 32'h8001_7FFF, 32'h0000_8001, 2);
      do_load("lb3",  3'b000, 5'd8, 32'h2003, 32'h8001_7FFF, 32'hFFFF_FF80, 0);
      do_load("lbu1", 3'b100, 5'd9, 32'h2001, 32'h8001_7FFF, 32'h0000_007F, 1);
      do_load("lh3",  3'b001, 5'd10, 32'h2003, 32'h8001_7FFF, 32'hFFFF_8001, 0);
      do_load("lw3",  3'b010, 5'd11, 32'h2003, 32'hCAFE_F00D, 32'hCAFE_F00D, 0);
      sb_drained("load");
   endtask

   task automatic test_jal_csr();
      push_wb(5'd1, 32'h104);
      issue(mk(7'b1101111, 5'd1, 3'b000, 12'd0), 32'h9999, 32'h104, 0, 0);
      @(posedge clk); #1;
      issue(mk(7'b1110011, 5'd3, 3'b001, 12'h51E), 32'h7777, 0, 0, 32'd1);
      @(negedge clk);
      checks++;
      if (wb_we !== 1'b0 || csr_tohost !== 32'd0) begin
         failures++;
         $display("FAIL csr_cycle: wb_we=%b tohost=%h expected 0/0", wb_we, csr_tohost);
      end
      @(posedge clk); #1;
      checks++;
      if (csr_tohost !== 32'd1) begin
         failures++;
         $display("FAIL csr_tohost: got %h expected 1", csr_tohost);
      end
      issue(mk(7'b1110011, 5'd0, 3'b001, 12'h300), 0, 0, 0, 32'd5);
      @(posedge clk); #1;
      checks++;
      if (csr_tohost !== 32'd1) begin
         failures++;
         $display("FAIL csr_other: got %h expected 1", csr_tohost);
      end
      sb_drained("jal_csr");
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++) begin
         x_inst = mk(7'b0010011, 5'(12 + i), 3'b000, 12'd0);
         x_alu_out = 32'h100 + i * 7;
         push_wb(5'(12 + i), 32'h100 + i * 7);
         @(posedge clk); #1;
      end
      x_inst = NOP;
      x_alu_out = '0;
      @(posedge clk); #1;
      sb_drained("b2b");
   endtask

`ifdef MWB_PERF_CNT_EN
   task automatic test_perf();
      apply_reset();
      issue(NOP, 0, 0, 0, 0);
      push_wb(5'd5, 32'h55);
      issue(mk(7'b0110011, 5'd5, 3'b000, 12'd0), 32'h55, 0, 0, 0);
      do_load("perf_lw", 3'b010, 5'd7, 32'h40, 32'h1111_2222, 32'h1111_2222, 1);
      @(posedge clk); #1;
      checks++;
      if (instret_cnt !== 32'd2 || stall_cnt !== 32'd2) begin
         failures++;
         $display("FAIL perf_cnt: instret=%0d stall=%0d expected 2/2", instret_cnt, stall_cnt);
      end
      sb_drained("perf");
   endtask
`endif

   initial begin
      dc_if.req_ready = 1'b1;
      dc_if.resp_valid = 1'b0;
      dc_if.dout = '0;
      test_reset();
      test_alu();
      test_store_stall();
      test_store_enc();
      test_load();
      test_jal_csr();
      test_back_to_back();
`ifdef MWB_PERF_CNT_EN
      test_perf();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
